lif_neuron_bank: RTL and testbench

Four-neuron leaky integrate-and-fire (LIF) bank that sits directly downstream of the sparse MVM accelerator. It consumes the four per-row dot-product results, each announced by a toggle strobe on the accelerator's `sending_out` line. It integrates each result into a per-neuron membrane potential with leak, thresholds it, and emits a 4-bit spike vector. That vector is the spike train the CPU returns to the accelerator for the next timestep.

---
 rtl/lif_neuron_bank.sv | 150 +++++++++++++++
 tb/tb_lif_neuron_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_bank.sv
// Four-neuron leaky integrate-and-fire bank fed by a toggle-strobed MVM result stream.
// Optional refractory period: define LIF_REFRACTORY_EN.
module lif_neuron_bank #(
  parameter int unsigned POT_W      = 10,
  parameter int unsigned THRESHOLD  = 64,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_val,
  input  logic       in_tog,
  input  logic       clear,
  output logic [3:0] spikes,
  output logic       spikes_valid,
  output logic       busy,
  output logic       overrun
);

  localparam logic [POT_W-1:0] THR     = POT_W'(THRESHOLD);
  localparam logic [POT_W:0]   POT_MAX = {1'b0, {POT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_UPDATE  = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             tog_q;
  logic             strobe;
  logic             capture;
  logic             drop;
  logic [1:0]       idx_q;
  logic [1:0]       ucnt_q;
  logic [7:0]       buf_q [4];
  logic [POT_W-1:0] pot_q [4];
  logic [2:0]       spk_acc_q;
  logic [POT_W-1:0] pot_sel;
  logic [POT_W-1:0] pot_nxt;
  logic [7:0]       in_sel;
  logic             fire;

  // One extra bit of headroom so the sum can be saturated instead of wrapping.
  function automatic logic [POT_W:0] leak_integrate(input logic [POT_W-1:0] v,
                                                    input logic [7:0]       din);
    leak_integrate = {1'b0, v} - ({1'b0, v} >> LEAK_SHIFT) + (POT_W+1)'(din);
  endfunction

  function automatic logic [POT_W-1:0] sat_pot(input logic [POT_W:0] v);
    sat_pot = (v > POT_MAX) ? {POT_W{1'b1}} : v[POT_W-1:0];
  endfunction

  assign strobe  = in_tog ^ tog_q;
  assign pot_sel = pot_q[ucnt_q];

`ifdef LIF_REFRACTORY_EN
  logic [3:0] refr_q;

  assign in_sel  = refr_q[ucnt_q] ? 8'd0 : buf_q[ucnt_q];
  assign pot_nxt = sat_pot(leak_integrate(pot_sel, in_sel));
  assign fire    = !refr_q[ucnt_q] && (pot_nxt >= THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refr_q <= 4'd0;
    end else if (clear) begin
      refr_q <= 4'd0;
    end else if (state_q == S_UPDATE && ucnt_q == 2'd3) begin
      refr_q <= {fire, spk_acc_q};
    end
  end
`else
  assign in_sel  = buf_q[ucnt_q];
  assign pot_nxt = sat_pot(leak_integrate(pot_sel, in_sel));
  assign fire    = (pot_nxt >= THR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    drop         = 1'b0;
    busy         = (state_q != S_COLLECT);
    spikes_valid = (state_q == S_EMIT);
    if (clear) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT, S_EMIT: begin
          if (state_q == S_EMIT) state_d = S_COLLECT;
          if (strobe) begin
            capture = 1'b1;
            if (idx_q == 2'd3) state_d = S_UPDATE;
          end
        end
        S_UPDATE: begin
          drop = strobe;
          if (ucnt_q == 2'd3) state_d = S_EMIT;
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  // Capture / integrate stage: one neuron per UPDATE cycle, vector published on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q     <= 1'b0;
      idx_q     <= 2'd0;
      ucnt_q    <= 2'd0;
      spk_acc_q <= 3'd0;
      spikes    <= 4'd0;
      overrun   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
        pot_q[i] <= '0;
      end
    end else begin
      tog_q <= in_tog;
      if (clear) begin
        idx_q     <= 2'd0;
        ucnt_q    <= 2'd0;
        spk_acc_q <= 3'd0;
        spikes    <= 4'd0;
        overrun   <= 1'b0;
        for (int i = 0; i < 4; i++) pot_q[i] <= '0;
      end else begin
        if (capture) begin
          buf_q[idx_q] <= in_val;
          idx_q        <= idx_q + 2'd1;
        end
        if (drop) overrun <= 1'b1;
        if (state_q == S_UPDATE) begin
          pot_q[ucnt_q] <= fire ? '0 : pot_nxt;
          ucnt_q        <= ucnt_q + 2'd1;
          if (ucnt_q == 2'd3) spikes <= {fire, spk_acc_q};
          else                spk_acc_q[ucnt_q] <= fire;
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_bank.sv
// Self-checking bench for lif_neuron_bank: hand vector table, directed corner sequences,
// and randomized frames against an arithmetic reference model.
module tb_lif_neuron_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_val;
  logic       in_tog;
  logic       clear;
  logic [3:0] spikes;
  logic       spikes_valid;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  lif_neuron_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_val       (in_val),
    .in_tog       (in_tog),
    .clear        (clear),
    .spikes       (spikes),
    .spikes_valid (spikes_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int         mv [4];
  logic [3:0] mlast;
  logic       exp_ovr;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mv[i] = 0;
    mlast   = 4'd0;
    exp_ovr = 1'b0;
  endtask

  // Threshold 64, leak v/8, saturation at 1023.
  task automatic model_frame(input int ins [4], output logic [3:0] sp);
    int nv;
    int din;
    for (int i = 0; i < 4; i++) begin
      din = ins[i];
`ifdef LIF_REFRACTORY_EN
      if (mlast[i]) din = 0;
`endif
      nv = mv[i] - mv[i] / 8 + din;
      if (nv > 1023) nv = 1023;
      sp[i] = (nv >= 64);
`ifdef LIF_REFRACTORY_EN
      if (mlast[i]) sp[i] = 1'b0;
`endif
      mv[i] = sp[i] ? 0 : nv;
    end
    mlast = sp;
  endtask

  task automatic send4(input int ins [4]);
    for (int k = 0; k < 4; k++) begin
      in_val = 8'(ins[k]);
      in_tog = ~in_tog;
      @(posedge clk); #1;
      if (k < 3) begin
        chk("busy_collect", int'(busy), 0);
        chk("sv_collect", int'(spikes_valid), 0);
      end
    end
  endtask

  // Returns one time unit after edge C4+4 (spike pulse visible).
  task automatic run_frame(input int v0, input int v1, input int v2, input int v3,
                           input int ovr_edge);
    int         ins [4];
    logic [3:0] sp;
    logic [3:0] prev;
    ins  = '{v0, v1, v2, v3};
    prev = mlast;
    send4(ins);
    model_frame(ins, sp);
    chk("busy_c4", int'(busy), 1);
    for (int e = 1; e <= 4; e++) begin
      if (ovr_edge == e) begin
        in_val  = 8'($urandom_range(0, 255));
        in_tog  = ~in_tog;
        exp_ovr = 1'b1;
      end
      @(posedge clk); #1;
      if (e < 4) begin
        chk("sv_update", int'(spikes_valid), 0);
        chk("spikes_hold", int'(spikes), int'(prev));
      end
    end
    chk("sv_emit", int'(spikes_valid), 1);
    chk("busy_emit", int'(busy), 1);
    chk("spikes", int'(spikes), int'(sp));
    chk("overrun", int'(overrun), int'(exp_ovr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        chk("sv_drop", int'(spikes_valid), 0);
        chk("busy_drop", int'(busy), 0);
      end
    end
  endtask

  // Clear with a simultaneous strobe that must be ignored.
  task automatic do_clear();
    clear  = 1'b1;
    in_val = 8'd200;
    in_tog = ~in_tog;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    chk("clr_overrun", int'(overrun), 0);
    chk("clr_spikes", int'(spikes), 0);
    chk("clr_sv", int'(spikes_valid), 0);
    chk("clr_busy", int'(busy), 0);
  endtask

  function automatic int rv();
    if ($urandom_range(0, 7) == 0) return 255;
    return int'($urandom_range(0, 45));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ovr;
    int sel;
    int        burst [4];

    tbl[0] = '{8'd70,  8'd10, 8'd0,   8'd64, 4'b1001};
    tbl[1] = '{8'd0,   8'd54, 8'd0,   8'd0,  4'b0000};
    tbl[2] = '{8'd0,   8'd0,  8'd40,  8'd0,  4'b0000};
    tbl[3] = '{8'd0,   8'd0,  8'd40,  8'd0,  4'b0100};
    tbl[4] = '{8'd100, 8'd0,  8'd0,   8'd0,  4'b0001};
`ifdef LIF_REFRACTORY_EN
    tbl[5] = '{8'd100, 8'd0,  8'd0,   8'd0,  4'b0000};
`else
    tbl[5] = '{8'd100, 8'd0,  8'd0,   8'd0,  4'b0001};
`endif
    tbl[6] = '{8'd100, 8'd0,  8'd0,   8'd0,  4'b0001};
    tbl[7] = '{8'd0,   8'd30, 8'd0,   8'd0,  4'b0000};
    tbl[8] = '{8'd0,   8'd4,  8'd255, 8'd0,  4'b0100};

    rst_n  = 1'b0;
    in_val = 8'd0;
    in_tog = 1'b0;
    clear  = 1'b0;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      in_val = 8'($urandom);
      in_tog = 1'($urandom);
      clear  = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_spikes", int'(spikes), 0);
      chk("rst_sv", int'(spikes_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
    end
    in_tog = 1'b0;
    clear  = 1'b0;
    rst_n  = 1'b1;

    // Hand-derived frames; odd entries start the next frame on edge C4+5
    for (int i = 0; i < 9; i++) begin
      run_frame(int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].c), int'(tbl[i].d), 0);
      chk("tbl_spikes", int'(spikes), int'(tbl[i].exp));
      if (i % 2 == 0) idle(1);
    end

    // Overrun at C4+2, then next frame still maps its first strobe to neuron 0
    run_frame(0, 0, 0, 0, 2);
    run_frame(64, 0, 0, 0, 0);
    chk("ovr_next_n0", int'(spikes), 1);
    chk("ovr_sticky", int'(overrun), 1);
    idle(1);

    do_clear();
    run_frame(0, 0, 0, 70, 3);
    chk("clr_next_n3", int'(spikes), 8);

    // Async reset in the middle of UPDATE
    burst = '{70, 70, 70, 70};
    send4(burst);
    @(posedge clk); #1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_spikes", int'(spikes), 0);
    chk("arst_sv", int'(spikes_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overrun", int'(overrun), 0);
    in_tog = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold_busy", int'(busy), 0);
    rst_n = 1'b1;
    model_reset();
    run_frame(70, 10, 0, 64, 0);
    chk("arst_first_frame", int'(spikes), 9);
    idle(1);

    // Randomized frames against the reference model
    for (int f = 0; f < 40; f++) begin
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_frame(rv(), rv(), rv(), rv(), ovr);
      sel = int'($urandom_range(0, 9));
      if (sel == 0) do_clear();
      else if (sel < 4) idle(int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
